// File: rtl/pll_cen_gen_if.sv
// Config write channel for pll_cen_gen: valid/ready handshake carrying a target channel and a new phase increment.
interface pll_cen_gen_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (output cfg_valid, output cfg_ch, output cfg_inc, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_inc, output cfg_ready);
endinterface

// File: rtl/pll_cen_gen.sv
// NCO-based clock-enable generator gated by a debounced PLL lock; ce/ce_n are registered, one cycle after the causing add.
// Config writes are never back-pressured once out of reset; new increments take effect at the channel's next wrap.
module pll_cen_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked,
    pll_cen_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] ce_n,
    output logic              ready
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic             lk;
    logic             cfg_ready_q;
    logic             run_stay;
    logic             wr_acc;

    logic [ACC_W-1:0] acc_q    [NUM_CH];
    logic [ACC_W-1:0] acc_d    [NUM_CH];
    logic [ACC_W-1:0] inc_q    [NUM_CH];
    logic [ACC_W-1:0] inc_d    [NUM_CH];
    logic [ACC_W-1:0] shadow_q [NUM_CH];
    logic [ACC_W-1:0] shadow_d [NUM_CH];
    logic [ACC_W:0]   sum      [NUM_CH];

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] ce_n_q, ce_n_d;
    logic [NUM_CH-1:0] wr_hit;

    assign lk     = sync_q[1];
    assign wr_acc = cfg.cfg_valid & cfg_ready_q;

    // Out-of-range channel numbers match no g_ch slot, so such writes are accepted and dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign sum[g]    = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
        assign wr_hit[g] = wr_acc & (cfg.cfg_ch == CH_W'(g));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lk) state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!lk) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Adds only happen on edges that keep us in RUN; leaving RUN zeroes the NCOs and pulses together.
    assign run_stay = (state_q == RUN) && (state_d == RUN);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i]    = '0;
            inc_d[i]    = inc_q[i];
            shadow_d[i] = shadow_q[i];
            pend_d[i]   = pend_q[i];
            ce_d[i]     = 1'b0;
            ce_n_d[i]   = 1'b0;
            if (run_stay) begin
                acc_d[i]  = sum[i][ACC_W-1:0];
                ce_d[i]   = sum[i][ACC_W];
                ce_n_d[i] = ~acc_q[i][ACC_W-1] & sum[i][ACC_W-1];
            end
            // A frozen or idle channel has no wrap to wait for, so its update lands immediately.
            if (pend_q[i] && ((state_q != RUN) || (inc_q[i] == '0) || (run_stay && sum[i][ACC_W]))) begin
                inc_d[i]  = shadow_q[i];
                pend_d[i] = 1'b0;
            end
            if (wr_hit[i]) begin
                shadow_d[i] = cfg.cfg_inc;
                pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b0;
            pend_q      <= '0;
            ce_q        <= '0;
            ce_n_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]    <= '0;
                inc_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            sync_q      <= {sync_q[0], pll_locked};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_ready_q <= 1'b1;
            pend_q      <= pend_d;
            ce_q        <= ce_d;
            ce_n_q      <= ce_n_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]    <= acc_d[i];
                inc_q[i]    <= inc_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign ce            = ce_q;
    assign ce_n          = ce_n_q;
    assign ready         = (state_q == RUN);
    assign cfg.cfg_ready = cfg_ready_q;
endmodule

// File: tb/tb_pll_cen_gen.sv
// Bench for pll_cen_gen: randomized config/lock stimulus against an integer phase model plus directed timing checks.
module tb_pll_cen_gen;
    localparam int NUM_CH      = 5;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = 3;
    localparam int MOD         = 1 << ACC_W;
    localparam int HALF        = MOD / 2;

    logic              refclk = 1'b0;
    logic              rst_n;
    logic              pll_locked;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] ce_n;
    logic              ready;

    pll_cen_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg_if ();

    pll_cen_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .cfg       (cfg_if.slave),
        .ce        (ce),
        .ce_n      (ce_n),
        .ready     (ready)
    );

    always #5 refclk = ~refclk;

    // Reference model: integer phases; "running" means the last LOCK_CYCLES+1 lock samples, two edges back, were all high.
    int                m_phase [NUM_CH];
    int                m_inc   [NUM_CH];
    int                m_sh    [NUM_CH];
    bit                m_pend  [NUM_CH];
    logic [NUM_CH-1:0] m_ce, m_cen;
    logic              m_ready, m_cfg_rdy;
    int                stk0, stk1, stk2;
    int                cyc;
    int                n_chk, n_pass;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_phase[i] = 0; m_inc[i] = 0; m_sh[i] = 0; m_pend[i] = 1'b0;
        end
        m_ce = '0; m_cen = '0; m_ready = 1'b0; m_cfg_rdy = 1'b0;
        stk0 = 0; stk1 = 0; stk2 = 0;
    endfunction

    function automatic void model_edge();
        bit prev, stay, carry;
        int s, np;
        prev = m_ready;
        stk2 = stk1;
        stk1 = stk0;
        stk0 = (pll_locked === 1'b1) ? stk0 + 1 : 0;
        m_ready = (stk2 >= LOCK_CYCLES + 1);
        stay = prev && m_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            s = m_phase[i] + m_inc[i];
            np = s % MOD;
            carry = (s >= MOD);
            m_ce[i]  = stay && carry;
            m_cen[i] = stay && (m_phase[i] < HALF) && (np >= HALF);
            if (m_pend[i] && (!prev || m_inc[i] == 0 || (stay && carry))) begin
                m_inc[i]  = m_sh[i];
                m_pend[i] = 1'b0;
            end
            m_phase[i] = stay ? np : 0;
        end
        if (cfg_if.cfg_valid === 1'b1 && m_cfg_rdy && int'(cfg_if.cfg_ch) < NUM_CH) begin
            m_sh[int'(cfg_if.cfg_ch)]   = int'(cfg_if.cfg_inc);
            m_pend[int'(cfg_if.cfg_ch)] = 1'b1;
        end
        m_cfg_rdy = 1'b1;
    endfunction

    task automatic step();
        @(posedge refclk);
        model_edge();
        cyc++;
        #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic drive_cfg(input int ch, input int inc);
        logic [31:0] c, v;
        c = ch;
        v = inc;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = c[CH_W-1:0];
        cfg_if.cfg_inc   = v[ACC_W-1:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_inc = '0;
        model_reset();
        #12;
        n_chk++;
        if ({ready, ce, ce_n, cfg_if.cfg_ready} !== '0)
            $display("FAIL reset_outputs got rdy=%b ce=%b ce_n=%b cfg_rdy=%b want all 0", ready, ce, ce_n, cfg_if.cfg_ready);
        else n_pass++;
        @(negedge refclk);
        rst_n = 1'b1; pll_locked = 1'b1;
        cyc = -1;
        for (int k = 0; k < 22; k++) begin
            step();
            n_chk++;
            if (ready !== (k >= LOCK_CYCLES + 2) || ce !== '0 || ce_n !== '0)
                $display("FAIL lock_timing edge=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=0 ce_n=0", k, ready, ce, ce_n, k >= LOCK_CYCLES + 2);
            else n_pass++;
        end
        n_chk++;
        if (cfg_if.cfg_ready !== 1'b1) $display("FAIL cfg_ready got %b want 1", cfg_if.cfg_ready);
        else n_pass++;
    endtask

    task automatic test_ch0_rate();
        int q_ce[$], q_cen[$];
        drive_cfg(0, 64);
        for (int k = 0; k < 40; k++) begin
            step();
            n_chk++;
            if ({ready, ce, ce_n} !== {m_ready, m_ce, m_cen})
                $display("FAIL ch0_rate cyc=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=%b ce_n=%b", cyc, ready, ce, ce_n, m_ready, m_ce, m_cen);
            else n_pass++;
            if (ce[0]) q_ce.push_back(cyc);
            if (ce_n[0]) q_cen.push_back(cyc);
        end
        n_chk++;
        if (q_ce.size() < 8 || q_cen.size() < 8) $display("FAIL ch0_count got ce=%0d ce_n=%0d want >=8 each", q_ce.size(), q_cen.size());
        else n_pass++;
        for (int i = 0; i + 1 < q_ce.size(); i++) begin
            n_chk++;
            if (q_ce[i+1] - q_ce[i] != 4) $display("FAIL ch0_period got %0d want 4", q_ce[i+1] - q_ce[i]);
            else n_pass++;
        end
        for (int i = 0; i < q_cen.size() && q_ce.size() > 0; i++) begin
            n_chk++;
            if ((q_cen[i] - q_ce[0] + 400) % 4 != 2) $display("FAIL ch0_cen_offset got %0d want 2", (q_cen[i] - q_ce[0] + 400) % 4);
            else n_pass++;
        end
    endtask

    task automatic test_rate_change();
        int p[$];
        int w2, dly;
        drive_cfg(1, 32);
        for (int k = 0; k < 20; k++) begin
            step();
            n_chk++;
            if ({ready, ce, ce_n} !== {m_ready, m_ce, m_cen})
                $display("FAIL rate_warm cyc=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=%b ce_n=%b", cyc, ready, ce, ce_n, m_ready, m_ce, m_cen);
            else n_pass++;
        end
        // Pass 0: single write of 128 (gaps 8,2,2). Pass 1: 128 then 255 before the wrap (gaps 8,2,1).
        for (int pass = 0; pass < 2; pass++) begin
            p.delete();
            dly = (pass == 0) ? 1 : $urandom_range(0, 2);
            w2 = -1;
            for (int k = 0; k < 60 && p.size() < 4; k++) begin
                step();
                n_chk++;
                if ({ready, ce, ce_n} !== {m_ready, m_ce, m_cen})
                    $display("FAIL rate_change cyc=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=%b ce_n=%b", cyc, ready, ce, ce_n, m_ready, m_ce, m_cen);
                else n_pass++;
                if (ce[1]) p.push_back(cyc);
                if (p.size() == 1 && cyc == p[0] + dly) begin
                    drive_cfg(1, 128);
                    if (pass == 1) w2 = cyc + 1;
                end
                if (cyc == w2) drive_cfg(1, 255);
            end
            n_chk++;
            if (p.size() != 4) $display("FAIL rate_pulses pass=%0d got %0d want 4", pass, p.size());
            else n_pass++;
            if (p.size() == 4) begin
                n_chk++;
                if (p[1] - p[0] != 8 || p[2] - p[1] != 2 || p[3] - p[2] != ((pass == 0) ? 2 : 1))
                    $display("FAIL rate_gaps pass=%0d got %0d,%0d,%0d want 8,2,%0d", pass, p[1]-p[0], p[2]-p[1], p[3]-p[2], (pass == 0) ? 2 : 1);
                else n_pass++;
            end
            if (pass == 0) begin
                drive_cfg(1, 32);
                for (int k = 0; k < 20; k++) step();
            end
        end
    endtask

    task automatic test_lock_loss();
        int m, rise, first;
        pll_locked = 1'b0;
        step();
        m = cyc;
        pll_locked = 1'b1;
        n_chk++;
        if (ready !== 1'b1) $display("FAIL loss_edge0 got rdy=%b want 1", ready);
        else n_pass++;
        step();
        n_chk++;
        if (ready !== 1'b1) $display("FAIL loss_edge1 got rdy=%b want 1", ready);
        else n_pass++;
        step();
        n_chk++;
        if (ready !== 1'b0 || ce !== '0 || ce_n !== '0)
            $display("FAIL loss_edge2 got rdy=%b ce=%b ce_n=%b want 0,0,0", ready, ce, ce_n);
        else n_pass++;
        rise = -1; first = -1;
        for (int k = 0; k < 60 && first < 0; k++) begin
            step();
            n_chk++;
            if ({ready, ce, ce_n} !== {m_ready, m_ce, m_cen})
                $display("FAIL relock cyc=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=%b ce_n=%b", cyc, ready, ce, ce_n, m_ready, m_ce, m_cen);
            else n_pass++;
            if (ready && rise < 0) rise = cyc;
            if (ce[0] && first < 0) first = cyc;
        end
        n_chk++;
        if (rise - m != LOCK_CYCLES + 3) $display("FAIL relock_time got %0d want %0d", rise - m, LOCK_CYCLES + 3);
        else n_pass++;
        n_chk++;
        if (first - rise != 4) $display("FAIL first_ce0 got %0d want 4", first - rise);
        else n_pass++;
    endtask

    task automatic test_random();
        int drop;
        drop = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) drive_cfg($urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
            if (drop > 0) begin
                drop--;
                if (drop == 0) pll_locked = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                pll_locked = 1'b0;
                drop = $urandom_range(1, 3);
            end
            step();
            n_chk++;
            if ({ready, ce, ce_n} !== {m_ready, m_ce, m_cen})
                $display("FAIL random cyc=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=%b ce_n=%b", cyc, ready, ce, ce_n, m_ready, m_ce, m_cen);
            else n_pass++;
        end
        pll_locked = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        for (int k = 0; k < 60 && !ready; k++) step();
        n_chk++;
        if (ready !== 1'b1) $display("FAIL pre_reset_run got rdy=%b want 1", ready);
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if ({ready, ce, ce_n, cfg_if.cfg_ready} !== '0)
            $display("FAIL async_reset got rdy=%b ce=%b ce_n=%b cfg_rdy=%b want all 0", ready, ce, ce_n, cfg_if.cfg_ready);
        else n_pass++;
        @(negedge refclk);
        rst_n = 1'b1;
        for (int k = 0; k < LOCK_CYCLES + 12; k++) begin
            step();
            n_chk++;
            if ({ready, ce, ce_n} !== {m_ready, m_ce, m_cen} || ce !== '0 || ce_n !== '0)
                $display("FAIL post_reset cyc=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=0 ce_n=0", cyc, ready, ce, ce_n, m_ready);
            else n_pass++;
        end
        n_chk++;
        if (ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_oor_and_full();
        int cnt;
        drive_cfg(7, 99); step();
        drive_cfg(5, 200); step();
        drive_cfg(6, 1);
        for (int k = 0; k < 30; k++) begin
            step();
            n_chk++;
            if (ce !== '0 || ce_n !== '0 || {ready, ce, ce_n} !== {m_ready, m_ce, m_cen})
                $display("FAIL oor_quiet cyc=%0d got ce=%b ce_n=%b want 0,0", cyc, ce, ce_n);
            else n_pass++;
        end
        drive_cfg(2, 255);
        for (int k = 0; k < 3; k++) step();
        cnt = 0;
        for (int k = 0; k < MOD; k++) begin
            step();
            n_chk++;
            if ({ready, ce, ce_n} !== {m_ready, m_ce, m_cen})
                $display("FAIL ch2_full cyc=%0d got rdy=%b ce=%b ce_n=%b want rdy=%b ce=%b ce_n=%b", cyc, ready, ce, ce_n, m_ready, m_ce, m_cen);
            else n_pass++;
            if (ce[2]) cnt++;
        end
        n_chk++;
        if (cnt != MOD - 1) $display("FAIL ch2_count got %0d want %0d", cnt, MOD - 1);
        else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        test_reset();
        test_ch0_rate();
        test_rate_change();
        test_lock_loss();
        test_random();
        test_reset_mid_run();
        test_oor_and_full();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
